// File: rtl/skew_rd_ctrl_pkg.sv
// Shared definitions for the skewed systolic read controller.
package skew_rd_ctrl_pkg;

    // Controller sequencing states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } skew_state_t;

    // LSB of a lane's slice inside the flattened per-lane address bus
    function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned stride);
        return lane * stride;
    endfunction

    // Cycle counter width: must hold WR_DELAY + N + 2^ROWS_WIDTH without overflow
    function automatic int unsigned cnt_width(input int unsigned wr_delay,
                                              input int unsigned lanes,
                                              input int unsigned rows_width);
        return $clog2(wr_delay + lanes + (1 << rows_width) + 1);
    endfunction

endpackage

// File: rtl/skew_lane_gen.sv
// One systolic lane: read enable and address as a function of cycle index t.
module skew_lane_gen
    import skew_rd_ctrl_pkg::*;
#(
    parameter int unsigned LANE       = 0,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned ROWS_WIDTH = 8,
    parameter int unsigned CNT_WIDTH  = 10
) (
    input  logic                  i_active,
    input  logic [CNT_WIDTH-1:0]  i_t,
    input  logic [ROWS_WIDTH-1:0] i_rows,
    input  logic [ADDR_WIDTH-1:0] i_base,
    output logic                  o_en_c,
    output logic [ADDR_WIDTH-1:0] o_addr_c
);

    logic [CNT_WIDTH-1:0] w_ofs;
    logic                 w_started;
    logic                 w_en;

    // Row offset within this lane: lane i starts i cycles after lane 0
    assign w_ofs     = i_t - CNT_WIDTH'(LANE);
    assign w_started = (i_t >= CNT_WIDTH'(LANE));

    // Enabled for exactly R cycles starting at t = LANE
    assign w_en = i_active && w_started && (w_ofs < CNT_WIDTH'(i_rows));

    // Address wraps modulo 2^ADDR_WIDTH; idle lanes drive zero
    assign o_en_c   = w_en;
    assign o_addr_c = w_en ? (i_base + ADDR_WIDTH'(w_ofs)) : '0;

endmodule

// File: rtl/skew_rd_ctrl.sv
// Skewed read-address generator feeding an N-lane systolic array, with
// delayed write-enable handoff and busy/done handshake.
module skew_rd_ctrl
    import skew_rd_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH_HEIGHT = 16,
    parameter int unsigned ADDR_WIDTH   = 8,
    parameter int unsigned ROWS_WIDTH   = 8,
    parameter int unsigned WR_DELAY     = WIDTH_HEIGHT + 1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start,
    input  logic                               abort,
    input  logic [ADDR_WIDTH-1:0]              base_addr,
    input  logic [ROWS_WIDTH-1:0]              num_rows,
    output logic [WIDTH_HEIGHT-1:0]            rd_en,
    output logic [WIDTH_HEIGHT*ADDR_WIDTH-1:0] rd_addr,
    output logic                               wr_active,
    output logic                               busy,
    output logic                               done
);

    localparam int unsigned CW = cnt_width(WR_DELAY, WIDTH_HEIGHT, ROWS_WIDTH);

    // Sequencing state and latched operands
    skew_state_t           r_state;
    logic [CW-1:0]         r_t;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [ROWS_WIDTH-1:0] r_rows;

    // Registered outputs
    logic [WIDTH_HEIGHT-1:0]            r_rd_en;
    logic [WIDTH_HEIGHT*ADDR_WIDTH-1:0] r_rd_addr;
    logic                               r_wr_active;
    logic                               r_busy;
    logic                               r_done;

    // Next-cycle values
    skew_state_t           w_state_nxt;
    logic [CW-1:0]         w_t_nxt;
    logic [ADDR_WIDTH-1:0] w_base_nxt;
    logic [ROWS_WIDTH-1:0] w_rows_nxt;
    logic                  w_done_nxt;
    logic                  w_read_nxt;
    logic                  w_busy_nxt;
    logic                  w_wr_nxt;

    logic [CW-1:0]         w_read_last;
    logic [CW-1:0]         w_drain_last;

    logic [WIDTH_HEIGHT-1:0]            w_lane_en;
    logic [WIDTH_HEIGHT*ADDR_WIDTH-1:0] w_lane_addr;

    // Last cycle index of each phase for the latched row count
    assign w_read_last  = CW'(WIDTH_HEIGHT) + CW'(r_rows) - CW'(2);
    assign w_drain_last = CW'(WR_DELAY) + w_read_last;

    // Next state, cycle index and operand latching; abort overrides everything
    always_comb begin
        w_state_nxt = r_state;
        w_t_nxt     = r_t;
        w_base_nxt  = r_base;
        w_rows_nxt  = r_rows;
        w_done_nxt  = 1'b0;

        if (abort) begin
            w_state_nxt = ST_IDLE;
            w_t_nxt     = '0;
            w_base_nxt  = '0;
            w_rows_nxt  = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (num_rows != '0) begin
                            w_state_nxt = ST_READ;
                            w_t_nxt     = '0;
                            w_base_nxt  = base_addr;
                            w_rows_nxt  = num_rows;
                        end else begin
                            // Empty transfer completes immediately
                            w_done_nxt = 1'b1;
                        end
                    end
                end
                ST_READ: begin
                    w_t_nxt = r_t + CW'(1);
                    if (r_t == w_read_last) begin
                        w_state_nxt = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (r_t == w_drain_last) begin
                        w_state_nxt = ST_IDLE;
                        w_t_nxt     = '0;
                        w_base_nxt  = '0;
                        w_rows_nxt  = '0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_t_nxt = r_t + CW'(1);
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_t_nxt     = '0;
                    w_base_nxt  = '0;
                    w_rows_nxt  = '0;
                end
            endcase
        end
    end

    // Output qualifiers for the upcoming cycle; DRAIN never runs past its last index
    assign w_read_nxt = (w_state_nxt == ST_READ);
    assign w_busy_nxt = (w_state_nxt != ST_IDLE);
    assign w_wr_nxt   = w_busy_nxt && (w_t_nxt >= CW'(WR_DELAY));

    // Per-lane enable/address generators, evaluated on next-cycle values
    for (genvar g = 0; g < WIDTH_HEIGHT; g++) begin : g_lane
        localparam int unsigned LSB = lane_lsb(g, ADDR_WIDTH);

        skew_lane_gen #(
            .LANE       (g),
            .ADDR_WIDTH (ADDR_WIDTH),
            .ROWS_WIDTH (ROWS_WIDTH),
            .CNT_WIDTH  (CW)
        ) u_lane (
            .i_active (w_read_nxt),
            .i_t      (w_t_nxt),
            .i_rows   (w_rows_nxt),
            .i_base   (w_base_nxt),
            .o_en_c   (w_lane_en[g]),
            .o_addr_c (w_lane_addr[LSB +: ADDR_WIDTH])
        );
    end

    // State, cycle index and operand registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_t     <= '0;
            r_base  <= '0;
            r_rows  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_t     <= w_t_nxt;
            r_base  <= w_base_nxt;
            r_rows  <= w_rows_nxt;
        end
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_en     <= '0;
            r_rd_addr   <= '0;
            r_wr_active <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_rd_en     <= w_lane_en;
            r_rd_addr   <= w_lane_addr;
            r_wr_active <= w_wr_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
        end
    end

    assign rd_en     = r_rd_en;
    assign rd_addr   = r_rd_addr;
    assign wr_active = r_wr_active;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_skew_rd_ctrl.sv
// Directed bench for skew_rd_ctrl: a 4-lane instance (WR_DELAY=5) for the
// detailed scenarios and a default 16-lane instance for the full-size case.
module tb_skew_rd_ctrl;

    logic       clk;
    logic       reset;
    logic       start;
    logic       abort;
    logic [7:0] base_addr;
    logic [7:0] num_rows;

    logic [3:0]   rd_en_a;
    logic [31:0]  rd_addr_a;
    logic         wr_a, busy_a, done_a;
    logic [15:0]  rd_en_b;
    logic [127:0] rd_addr_b;
    logic         wr_b, busy_b, done_b;

    logic [38:0] obs_a;
    assign obs_a = {rd_en_a, rd_addr_a, wr_a, busy_a, done_a};

    int n_checks = 0;
    int n_fail   = 0;

    skew_rd_ctrl #(
        .WIDTH_HEIGHT (4),
        .ADDR_WIDTH   (8),
        .ROWS_WIDTH   (8),
        .WR_DELAY     (5)
    ) dut_a (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .base_addr (base_addr),
        .num_rows  (num_rows),
        .rd_en     (rd_en_a),
        .rd_addr   (rd_addr_a),
        .wr_active (wr_a),
        .busy      (busy_a),
        .done      (done_a)
    );

    skew_rd_ctrl dut_b (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .base_addr (base_addr),
        .num_rows  (num_rows),
        .rd_en     (rd_en_b),
        .rd_addr   (rd_addr_b),
        .wr_active (wr_b),
        .busy      (busy_b),
        .done      (done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected {rd_en, rd_addr, wr_active, busy, done} of the 4-lane,
    // WR_DELAY=5 instance at cycle index t of a transfer with r rows.
    // busy ends at 5+4+r-2 = r+7, done at r+8.
    function automatic logic [38:0] exp_a(input int t, input logic [7:0] base, input int r);
        logic [3:0]  en;
        logic [31:0] ad;
        logic        wr, bz, dn;
        en = '0;
        ad = '0;
        for (int i = 0; i < 4; i++) begin
            if (r > 0 && t >= i && t <= i + r - 1) begin
                en[i]        = 1'b1;
                ad[i*8 +: 8] = base + 8'(t - i);
            end
        end
        bz = (r > 0) && (t <= r + 7);
        wr = (r > 0) && (t >= 5) && (t <= r + 7);
        dn = (r == 0) ? (t == 0) : (t == r + 8);
        return {en, ad, wr, bz, dn};
    endfunction

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; abort = 1'b1;
        base_addr = 8'h33; num_rows = 8'd2;
        tick(); tick();
        n_checks++;
        if (obs_a !== 39'd0) begin
            n_fail++;
            $display("FAIL reset_a: got %h expected 0", obs_a);
        end
        n_checks++;
        if ({rd_en_b, rd_addr_b, wr_b, busy_b, done_b} !== 147'd0) begin
            n_fail++;
            $display("FAIL reset_b: got en=%h busy=%b done=%b expected 0", rd_en_b, busy_b, done_b);
        end
        reset = 1'b0; start = 1'b0; abort = 1'b0;
        tick();
        n_checks++;
        if (obs_a !== 39'd0) begin
            n_fail++;
            $display("FAIL reset_release: got %h expected 0", obs_a);
        end
    endtask

    task automatic test_basic();
        logic [3:0] tbl [6];
        logic [7:0] exp3;
        tbl = '{4'h1, 4'h3, 4'h7, 4'hE, 4'hC, 4'h8};
        base_addr = 8'h10; num_rows = 8'd3; start = 1'b1;
        tick();
        start = 1'b0;
        for (int t = 0; t <= 12; t++) begin
            n_checks++;
            if (rd_en_a !== ((t < 6) ? tbl[t] : 4'h0)) begin
                n_fail++;
                $display("FAIL basic_en t=%0d: got %h expected %h", t, rd_en_a, (t < 6) ? tbl[t] : 4'h0);
            end
            n_checks++;
            if (obs_a !== exp_a(t, 8'h10, 3)) begin
                n_fail++;
                $display("FAIL basic t=%0d: got %h expected %h", t, obs_a, exp_a(t, 8'h10, 3));
            end
            if (t >= 3 && t <= 5) begin
                exp3 = 8'h10 + 8'(t - 3);
                n_checks++;
                if (rd_addr_a[31:24] !== exp3) begin
                    n_fail++;
                    $display("FAIL basic_lane3 t=%0d: got %h expected %h", t, rd_addr_a[31:24], exp3);
                end
            end
            tick();
        end
    endtask

    task automatic test_wrap();
        logic [7:0] tbl [4];
        tbl = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        base_addr = 8'hFE; num_rows = 8'd4; start = 1'b1;
        tick();
        start = 1'b0;
        for (int t = 0; t <= 13; t++) begin
            if (t < 4) begin
                n_checks++;
                if (rd_addr_a[7:0] !== tbl[t]) begin
                    n_fail++;
                    $display("FAIL wrap_lane0 t=%0d: got %h expected %h", t, rd_addr_a[7:0], tbl[t]);
                end
            end
            n_checks++;
            if (obs_a !== exp_a(t, 8'hFE, 4)) begin
                n_fail++;
                $display("FAIL wrap t=%0d: got %h expected %h", t, obs_a, exp_a(t, 8'hFE, 4));
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        base_addr = 8'h10; num_rows = 8'd3; start = 1'b1;
        tick();
        start = 1'b0;
        for (int t = 0; t <= 11; t++) begin
            n_checks++;
            if (obs_a !== exp_a(t, 8'h10, 3)) begin
                n_fail++;
                $display("FAIL ignore_start t=%0d: got %h expected %h", t, obs_a, exp_a(t, 8'h10, 3));
            end
            if (t == 2) begin
                start = 1'b1; base_addr = 8'h55; num_rows = 8'd7;
            end else if (t == 3) begin
                start = 1'b0;
            end
            if (t == 11) begin
                start = 1'b1; base_addr = 8'h20; num_rows = 8'd2;
            end
            tick();
        end
        start = 1'b0;
        for (int t = 0; t <= 11; t++) begin
            n_checks++;
            if (obs_a !== exp_a(t, 8'h20, 2)) begin
                n_fail++;
                $display("FAIL b2b t=%0d: got %h expected %h", t, obs_a, exp_a(t, 8'h20, 2));
            end
            tick();
        end
    endtask

    task automatic test_abort();
        base_addr = 8'h10; num_rows = 8'd3; start = 1'b1;
        tick();
        start = 1'b0;
        for (int t = 0; t <= 4; t++) begin
            n_checks++;
            if (obs_a !== exp_a(t, 8'h10, 3)) begin
                n_fail++;
                $display("FAIL abort_pre t=%0d: got %h expected %h", t, obs_a, exp_a(t, 8'h10, 3));
            end
            if (t == 4) abort = 1'b1;
            tick();
        end
        abort = 1'b0;
        for (int k = 0; k < 10; k++) begin
            n_checks++;
            if (obs_a !== 39'd0) begin
                n_fail++;
                $display("FAIL abort_post k=%0d: got %h expected 0", k, obs_a);
            end
            tick();
        end
        // abort and start together while idle: start is dropped
        abort = 1'b1; start = 1'b1; base_addr = 8'h44; num_rows = 8'd3;
        tick();
        abort = 1'b0; start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (obs_a !== 39'd0) begin
                n_fail++;
                $display("FAIL abort_start k=%0d: got %h expected 0", k, obs_a);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        base_addr = 8'h10; num_rows = 8'd3; start = 1'b1;
        tick();
        start = 1'b0;
        for (int t = 0; t <= 4; t++) begin
            if (t == 4) begin
                reset = 1'b1; abort = 1'b1;
            end
            tick();
        end
        reset = 1'b0; abort = 1'b0;
        for (int k = 0; k < 8; k++) begin
            n_checks++;
            if (obs_a !== 39'd0) begin
                n_fail++;
                $display("FAIL reset_mid k=%0d: got %h expected 0", k, obs_a);
            end
            tick();
        end
        base_addr = 8'h40; num_rows = 8'd1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int t = 0; t <= 10; t++) begin
            n_checks++;
            if (obs_a !== exp_a(t, 8'h40, 1)) begin
                n_fail++;
                $display("FAIL after_reset t=%0d: got %h expected %h", t, obs_a, exp_a(t, 8'h40, 1));
            end
            tick();
        end
    endtask

    task automatic test_zero_rows();
        base_addr = 8'h77; num_rows = 8'd0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int t = 0; t <= 11; t++) begin
            n_checks++;
            if (obs_a !== exp_a(t, 8'h77, 0)) begin
                n_fail++;
                $display("FAIL zero_rows t=%0d: got %h expected %h", t, obs_a, exp_a(t, 8'h77, 0));
            end
            tick();
        end
    endtask

    task automatic test_n16();
        logic [15:0] e16;
        logic [18:0] exp_v;
        logic [7:0]  exp15;
        int          last15;
        int          peaks;
        last15 = -1;
        peaks  = 0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        base_addr = 8'h00; num_rows = 8'd16; start = 1'b1;
        tick();
        start = 1'b0;
        for (int t = 0; t <= 50; t++) begin
            e16 = '0;
            for (int i = 0; i < 16; i++) begin
                if (t >= i && t <= i + 15) e16[i] = 1'b1;
            end
            exp_v = {e16, (t >= 17 && t <= 47), (t <= 47), (t == 48)};
            n_checks++;
            if ({rd_en_b, wr_b, busy_b, done_b} !== exp_v) begin
                n_fail++;
                $display("FAIL n16 t=%0d: got %h expected %h", t, {rd_en_b, wr_b, busy_b, done_b}, exp_v);
            end
            if (t >= 15 && t <= 30) begin
                exp15 = 8'(t - 15);
                n_checks++;
                if (rd_addr_b[127:120] !== exp15) begin
                    n_fail++;
                    $display("FAIL n16_lane15 t=%0d: got %h expected %h", t, rd_addr_b[127:120], exp15);
                end
            end
            if (rd_en_b[15] === 1'b1) last15 = t;
            if (rd_en_b === 16'hFFFF) peaks++;
            tick();
        end
        n_checks++;
        if (last15 !== 30) begin
            n_fail++;
            $display("FAIL n16_last_lane15: got t=%0d expected t=30", last15);
        end
        n_checks++;
        if (peaks !== 1) begin
            n_fail++;
            $display("FAIL n16_peak_count: got %0d expected 1", peaks);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0;
        base_addr = 8'h00; num_rows = 8'h00;
        test_reset();
        test_basic();
        test_wrap();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        test_zero_rows();
        test_n16();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
